rs_age_queue: RTL and testbench

Parametrised reservation station that buffers decoded instructions until their source operands are available, then dispatches one ready entry per cycle to a single execution unit. It sits between issue/decode and the ALU, and snoops `NUM_WB` write-back channels to wake waiting operands. It improves on the previous RS generation in three ways: oldest-ready-first selection through an age matrix, a valid/ready handshake toward the execution unit, and a correctly sized occupancy counter.

---
 rtl/rs_age_queue_pkg.sv | 15 +
 rtl/rs_age_queue_if.sv | 47 ++++
 rtl/rs_age_select.sv | 54 +++++
 rtl/rs_age_queue.sv | 141 ++++++++++++++
 tb/tb_rs_age_queue.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_age_queue_pkg.sv
// rtl/rs_age_queue_pkg.sv - shared sizing constants for the age-ordered reservation station
package rs_age_queue_pkg;

    localparam int RS_SIZE      = 8;
    localparam int ROB_SIZE_BIT = 4;
    localparam int RS_TYPE_BIT  = 5;
    localparam int RS_DATA_W    = 32;
    localparam int RS_NUM_WB    = 2;

    // Occupancy must represent DEPTH itself, hence one bit wider than the index.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rs_age_queue_if.sv
// rtl/rs_age_queue_if.sv - issue, dispatch and write-back signal bundle of the reservation station
interface rs_age_queue_if
    import rs_age_queue_pkg::*;
#(
    parameter int DEPTH  = RS_SIZE,
    parameter int NUM_WB = RS_NUM_WB,
    parameter int DATA_W = RS_DATA_W,
    parameter int TAG_W  = ROB_SIZE_BIT,
    parameter int OP_W   = RS_TYPE_BIT
) ();
    localparam int CNT_W = cnt_width(DEPTH);

    logic                     in_valid;
    logic                     in_ready;
    logic [OP_W-1:0]          in_op;
    logic [TAG_W-1:0]         in_tag;
    logic [DATA_W-1:0]        in_val1;
    logic [DATA_W-1:0]        in_val2;
    logic [TAG_W-1:0]         in_dep1;
    logic [TAG_W-1:0]         in_dep2;
    logic                     in_has_dep1;
    logic                     in_has_dep2;
    logic                     full;
    logic [CNT_W-1:0]         count;
    logic                     iss_valid;
    logic                     iss_ready;
    logic [OP_W-1:0]          iss_op;
    logic [TAG_W-1:0]         iss_tag;
    logic [DATA_W-1:0]        iss_val1;
    logic [DATA_W-1:0]        iss_val2;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*TAG_W-1:0]  wb_tag;
    logic [NUM_WB*DATA_W-1:0] wb_value;

    modport slave (
        input  in_valid, in_op, in_tag, in_val1, in_val2, in_dep1, in_dep2,
               in_has_dep1, in_has_dep2, iss_ready, wb_valid, wb_tag, wb_value,
        output in_ready, full, count, iss_valid, iss_op, iss_tag, iss_val1, iss_val2
    );

    modport master (
        output in_valid, in_op, in_tag, in_val1, in_val2, in_dep1, in_dep2,
               in_has_dep1, in_has_dep2, iss_ready, wb_valid, wb_tag, wb_value,
        input  in_ready, full, count, iss_valid, iss_op, iss_tag, iss_val1, iss_val2
    );

endinterface

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - age matrix with oldest-ready pick and index encode
module rs_age_select
    import rs_age_queue_pkg::*;
#(
    parameter int DEPTH = RS_SIZE,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en,
    input  logic             clear,
    input  logic [DEPTH-1:0] ready,
    input  logic [DEPTH-1:0] busy,
    input  logic [DEPTH-1:0] ins_onehot,
    output logic [IDX_W-1:0] sel_idx,
    output logic             any_ready
);

    // older[i][j] set means entry i was inserted before entry j.
    logic [DEPTH-1:0] older [DEPTH];
    logic [DEPTH-1:0] sel_onehot;

    always_ff @(posedge clk_in) begin
        if (!rst_in || clear) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else if (en) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (ins_onehot[k]) begin
                    older[k] <= '0;
                    for (int i = 0; i < DEPTH; i++) older[i][k] <= busy[i];
                end
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && older[j][i]) blocked = 1'b1;
            end
            sel_onehot[i] = ready[i] && !blocked;
        end
        // Ages form a total order over busy entries, so the pick is one-hot.
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_onehot[i]) sel_idx = sel_idx | IDX_W'(i);
        end
        any_ready = |ready;
    end

endmodule

// File: rtl/rs_age_queue.sv
// rtl/rs_age_queue.sv - reservation station with wakeup snooping and oldest-ready dispatch
module rs_age_queue
    import rs_age_queue_pkg::*;
#(
    parameter int DEPTH  = RS_SIZE,
    parameter int NUM_WB = RS_NUM_WB,
    parameter int DATA_W = RS_DATA_W,
    parameter int TAG_W  = ROB_SIZE_BIT,
    parameter int OP_W   = RS_TYPE_BIT
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush,
    rs_age_queue_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DEPTH-1:0]  busy, hd1, hd2, ready;
    logic [OP_W-1:0]   op_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q [DEPTH];
    logic [DATA_W-1:0] v1_q  [DEPTH];
    logic [DATA_W-1:0] v2_q  [DEPTH];
    logic [TAG_W-1:0]  d1_q  [DEPTH];
    logic [TAG_W-1:0]  d2_q  [DEPTH];
    logic [CNT_W-1:0]  count_q, count_next;
    logic              full_q;

    logic [DEPTH-1:0]  hit1, hit2;
    logic [DATA_W-1:0] wv1 [DEPTH];
    logic [DATA_W-1:0] wv2 [DEPTH];
    logic              in_hit1, in_hit2;
    logic [DATA_W-1:0] in_wv1, in_wv2;

    logic [IDX_W-1:0]  ins_idx, sel_idx;
    logic [DEPTH-1:0]  ins_onehot;
    logic              any_ready, iss_valid, in_fire, iss_fire;

    // Lowest write-back channel wins when several carry the same tag.
    function automatic logic [DATA_W:0] snoop(
        input logic [TAG_W-1:0]         dep,
        input logic [NUM_WB-1:0]        v,
        input logic [NUM_WB*TAG_W-1:0]  t,
        input logic [NUM_WB*DATA_W-1:0] d
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int c = NUM_WB - 1; c >= 0; c--) begin
            if (v[c] && t[c*TAG_W +: TAG_W] == dep) r = {1'b1, d[c*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {hit1[i], wv1[i]} = snoop(d1_q[i], bus.wb_valid, bus.wb_tag, bus.wb_value);
            {hit2[i], wv2[i]} = snoop(d2_q[i], bus.wb_valid, bus.wb_tag, bus.wb_value);
        end
        {in_hit1, in_wv1} = snoop(bus.in_dep1, bus.wb_valid, bus.wb_tag, bus.wb_value);
        {in_hit2, in_wv2} = snoop(bus.in_dep2, bus.wb_valid, bus.wb_tag, bus.wb_value);
    end

    always_comb begin
        logic found;
        found   = 1'b0;
        ins_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy[i] && !found) begin
                found   = 1'b1;
                ins_idx = IDX_W'(i);
            end
        end
    end

    assign ready      = busy & ~hd1 & ~hd2;
    assign in_fire    = bus.in_valid && !full_q && rdy_in;
    assign iss_valid  = rst_in && rdy_in && any_ready;
    assign iss_fire   = iss_valid && bus.iss_ready;
    assign ins_onehot = in_fire ? ({{(DEPTH-1){1'b0}}, 1'b1} << ins_idx) : '0;
    assign count_next = count_q + CNT_W'(in_fire) - CNT_W'(iss_fire);

    rs_age_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_age (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .en         (rdy_in),
        .clear      (flush),
        .ready      (ready),
        .busy       (busy),
        .ins_onehot (ins_onehot),
        .sel_idx    (sel_idx),
        .any_ready  (any_ready)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in || flush) begin
            busy    <= '0;
            hd1     <= '0;
            hd2     <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && hd1[i] && hit1[i]) begin
                    v1_q[i] <= wv1[i];
                    hd1[i]  <= 1'b0;
                end
                if (busy[i] && hd2[i] && hit2[i]) begin
                    v2_q[i] <= wv2[i];
                    hd2[i]  <= 1'b0;
                end
            end
            if (iss_fire) busy[sel_idx] <= 1'b0;
            // The insert slot is free, so it never collides with wakeup or issue above.
            if (in_fire) begin
                busy[ins_idx]  <= 1'b1;
                op_q[ins_idx]  <= bus.in_op;
                tag_q[ins_idx] <= bus.in_tag;
                d1_q[ins_idx]  <= bus.in_dep1;
                d2_q[ins_idx]  <= bus.in_dep2;
                v1_q[ins_idx]  <= bus.in_has_dep1 ? in_wv1 : bus.in_val1;
                v2_q[ins_idx]  <= bus.in_has_dep2 ? in_wv2 : bus.in_val2;
                hd1[ins_idx]   <= bus.in_has_dep1 && !in_hit1;
                hd2[ins_idx]   <= bus.in_has_dep2 && !in_hit2;
            end
            count_q <= count_next;
            full_q  <= (count_next == CNT_W'(DEPTH));
        end
    end

    assign bus.in_ready  = !rst_in || !full_q;
    assign bus.full      = full_q;
    assign bus.count     = count_q;
    assign bus.iss_valid = iss_valid;
    assign bus.iss_op    = iss_valid ? op_q[sel_idx]  : '0;
    assign bus.iss_tag   = iss_valid ? tag_q[sel_idx] : '0;
    assign bus.iss_val1  = iss_valid ? v1_q[sel_idx]  : '0;
    assign bus.iss_val2  = iss_valid ? v2_q[sel_idx]  : '0;

endmodule

// File: tb/tb_rs_age_queue.sv
// tb/tb_rs_age_queue.sv - scoreboard bench for rs_age_queue against an age-ordered list model
module tb_rs_age_queue;
    import rs_age_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int NWB   = 2;

    logic clk = 1'b0;
    logic rst, rdy, flush;
    always #5 clk = ~clk;

    rs_age_queue_if #(.DEPTH(DEPTH), .NUM_WB(NWB), .DATA_W(32), .TAG_W(4), .OP_W(5)) bus ();

    rs_age_queue #(.DEPTH(DEPTH), .NUM_WB(NWB), .DATA_W(32), .TAG_W(4), .OP_W(5)) u_dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .flush  (flush),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  tag;
        logic [31:0] v1, v2;
        logic        hd1, hd2;
        logic [3:0]  d1, d2;
    } ent_t;

    typedef struct {
        bit          live;
        bit          valid;
        bit          in_ready;
        int          count;
        bit          full;
        logic [4:0]  op;
        logic [3:0]  tag;
        logic [31:0] v1, v2;
    } exp_t;

    ent_t m_q[$];
    exp_t exp_q[$];
    logic [3:0] obs_tags[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        d_rst = 1'b0, d_rdy = 1'b1, d_flush = 1'b0, d_in_valid = 1'b0, d_iss_ready = 1'b0;
    logic [4:0]  d_op = '0;
    logic [3:0]  d_tag = '0, d_dep1 = '0, d_dep2 = '0;
    logic [31:0] d_v1 = '0, d_v2 = '0;
    logic        d_hd1 = 1'b0, d_hd2 = 1'b0;
    logic [1:0]  d_wbv = '0;
    logic [7:0]  d_wbt = '0;
    logic [63:0] d_wbd = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, want);
        end
    endtask

    function automatic bit wb_hit(input logic [3:0] dep, output logic [31:0] v);
        v = '0;
        for (int c = 0; c < NWB; c++) begin
            if (d_wbv[c] && d_wbt[c*4 +: 4] == dep) begin
                v = d_wbd[c*32 +: 32];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_eval();
        exp_t e;
        int idx;
        logic [31:0] v;
        ent_t n;
        idx = -1;
        foreach (m_q[i]) if (idx < 0 && !m_q[i].hd1 && !m_q[i].hd2) idx = i;
        e.live     = d_rst;
        e.valid    = d_rst && d_rdy && idx >= 0;
        e.in_ready = !d_rst || m_q.size() < DEPTH;
        e.count    = m_q.size();
        e.full     = m_q.size() == DEPTH;
        e.op = '0; e.tag = '0; e.v1 = '0; e.v2 = '0;
        if (e.valid) begin
            e.op = m_q[idx].op; e.tag = m_q[idx].tag; e.v1 = m_q[idx].v1; e.v2 = m_q[idx].v2;
        end
        exp_q.push_back(e);
        if (!d_rst || d_flush) begin
            m_q.delete();
        end else if (d_rdy) begin
            bit fire_in;
            fire_in = d_in_valid && m_q.size() < DEPTH;
            foreach (m_q[i]) begin
                if (m_q[i].hd1 && wb_hit(m_q[i].d1, v)) begin m_q[i].v1 = v; m_q[i].hd1 = 1'b0; end
                if (m_q[i].hd2 && wb_hit(m_q[i].d2, v)) begin m_q[i].v2 = v; m_q[i].hd2 = 1'b0; end
            end
            if (e.valid && d_iss_ready) m_q.delete(idx);
            if (fire_in) begin
                n.op = d_op; n.tag = d_tag; n.d1 = d_dep1; n.d2 = d_dep2;
                n.v1 = d_v1; n.v2 = d_v2; n.hd1 = d_hd1; n.hd2 = d_hd2;
                if (d_hd1 && wb_hit(d_dep1, v)) begin n.v1 = v; n.hd1 = 1'b0; end
                if (d_hd2 && wb_hit(d_dep2, v)) begin n.v2 = v; n.hd2 = 1'b0; end
                m_q.push_back(n);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        rst = d_rst; rdy = d_rdy; flush = d_flush;
        bus.in_valid = d_in_valid; bus.in_op = d_op; bus.in_tag = d_tag;
        bus.in_val1 = d_v1; bus.in_val2 = d_v2; bus.in_dep1 = d_dep1; bus.in_dep2 = d_dep2;
        bus.in_has_dep1 = d_hd1; bus.in_has_dep2 = d_hd2; bus.iss_ready = d_iss_ready;
        bus.wb_valid = d_wbv; bus.wb_tag = d_wbt; bus.wb_value = d_wbd;
        #2;
        model_eval();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ins(input logic [3:0] tag, input logic hd1, input logic [3:0] dep1,
                       input logic hd2, input logic [3:0] dep2);
        d_in_valid = 1'b1; d_tag = tag; d_op = 5'(tag + 4'd1);
        d_v1 = 32'h1000 + 32'(tag); d_v2 = 32'h2000 + 32'(tag);
        d_hd1 = hd1; d_dep1 = dep1; d_hd2 = hd2; d_dep2 = dep2;
        step();
        d_in_valid = 1'b0; d_hd1 = 1'b0; d_hd2 = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                check("iss_valid", 64'(bus.iss_valid), 64'(e.valid));
                check("in_ready", 64'(bus.in_ready), 64'(e.in_ready));
                if (e.live) begin
                    check("count", 64'(bus.count), 64'(e.count));
                    check("full", 64'(bus.full), 64'(e.full));
                end
                if (e.valid || !e.live) begin
                    check("iss_op", 64'(bus.iss_op), 64'(e.op));
                    check("iss_tag", 64'(bus.iss_tag), 64'(e.tag));
                    check("iss_val1", 64'(bus.iss_val1), 64'(e.v1));
                    check("iss_val2", 64'(bus.iss_val2), 64'(e.v2));
                end
                if (bus.iss_valid && bus.iss_ready && rdy) obs_tags.push_back(bus.iss_tag);
            end
        end
    end

    initial begin
        step();
        d_rst = 1'b1;
        idle(2);

        // Age order: the dependency-free youngest entry leaves first, then the two woken ones by age.
        d_iss_ready = 1'b1;
        obs_tags.delete();
        ins(4'd3, 1'b1, 4'd9, 1'b0, 4'd0);
        ins(4'd7, 1'b1, 4'd9, 1'b0, 4'd0);
        ins(4'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        d_wbv = 2'b01; d_wbt = {4'd0, 4'd9}; d_wbd = {32'h0, 32'h99};
        step();
        d_wbv = '0;
        idle(4);
        check("age_issue_count", 64'(obs_tags.size()), 64'd3);
        if (obs_tags.size() >= 3) begin
            check("age_first", 64'(obs_tags[0]), 64'd1);
            check("age_second", 64'(obs_tags[1]), 64'd3);
            check("age_third", 64'(obs_tags[2]), 64'd7);
        end

        // Backpressure holds one entry stable for four cycles.
        d_iss_ready = 1'b0;
        ins(4'd4, 1'b0, 4'd0, 1'b0, 4'd0);
        idle(4);
        d_iss_ready = 1'b1;
        idle(2);

        // Dual wakeup captured by the inserting entry itself.
        d_wbv = 2'b11; d_wbt = {4'd5, 4'd2}; d_wbd = {32'hBB, 32'hAA};
        ins(4'd6, 1'b1, 4'd2, 1'b1, 4'd5);
        d_wbv = '0;
        idle(2);

        // Full boundary: insert blocked while an issue frees a slot.
        d_iss_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ins(4'(i + 8), 1'b0, 4'd0, 1'b0, 4'd0);
        d_iss_ready = 1'b1;
        ins(4'd15, 1'b0, 4'd0, 1'b0, 4'd0);
        d_iss_ready = 1'b0;
        idle(2);
        d_iss_ready = 1'b1;
        idle(9);

        // Flush together with an insert discards everything.
        d_iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) ins(4'(i), 1'b0, 4'd0, 1'b0, 4'd0);
        d_flush = 1'b1;
        ins(4'd12, 1'b0, 4'd0, 1'b0, 4'd0);
        d_flush = 1'b0;
        step();
        d_iss_ready = 1'b1;
        ins(4'd13, 1'b0, 4'd0, 1'b0, 4'd0);
        idle(3);

        // Reset with live entries, then a stall that must ignore insert and wakeup.
        d_iss_ready = 1'b0;
        ins(4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        ins(4'd3, 1'b1, 4'd8, 1'b0, 4'd0);
        d_rst = 1'b0;
        step();
        d_rst = 1'b1;
        idle(2);
        d_iss_ready = 1'b1;
        ins(4'd2, 1'b1, 4'd8, 1'b0, 4'd0);
        d_rdy = 1'b0;
        d_wbv = 2'b10; d_wbt = {4'd8, 4'd0}; d_wbd = {32'h88, 32'h0};
        ins(4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        d_wbv = '0;
        d_rdy = 1'b1;
        idle(2);
        d_wbv = 2'b10;
        step();
        d_wbv = '0;
        idle(3);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            d_rst       = ($urandom_range(0, 149) != 0);
            d_flush     = ($urandom_range(0, 39) == 0);
            d_rdy       = ($urandom_range(0, 7) != 0);
            d_iss_ready = ($urandom_range(0, 2) != 0);
            d_in_valid  = ($urandom_range(0, 1) != 0);
            d_op        = 5'($urandom);
            d_tag       = 4'($urandom);
            d_v1        = $urandom;
            d_v2        = $urandom;
            d_hd1       = ($urandom_range(0, 2) == 0);
            d_hd2       = ($urandom_range(0, 2) == 0);
            d_dep1      = 4'($urandom);
            d_dep2      = 4'($urandom);
            d_wbv       = 2'($urandom);
            d_wbt       = 8'($urandom);
            d_wbd       = {$urandom, $urandom};
            step();
        end
        d_rst = 1'b1; d_flush = 1'b0; d_rdy = 1'b1; d_in_valid = 1'b0; d_wbv = '0;
        idle(4);
        @(negedge clk);
        #5;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
